// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter: instruction fetch and load/store share one 8-bit RAM, little-endian, load/store wins ties.
// Read N bytes: done in cycle N+1 after acceptance; write N bytes: done in cycle N. rdy_in low freezes everything.
// Define MEM_CTRL_IO_FULL_EN to hold off stores to mem_addr[17:16]==2'b11 while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_len,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, nb_q, nb_d, mem_nb;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic        fetch_q, fetch_d, wr_q, wr_d;
    logic [31:0] ram_a_d, if_data_d, mem_rdata_d;
    logic [7:0]  dout_d;
    logic        if_done_d, mem_done_d, mem_go, st_blocked;
    logic [1:0]  rd_idx, wr_idx;

`ifdef MEM_CTRL_IO_FULL_EN
    assign st_blocked = mem_we && (mem_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic io_full_unused;
    assign io_full_unused = io_buffer_full;
    assign st_blocked     = 1'b0;
`endif

    assign mem_go = mem_req && !st_blocked;
    assign mem_nb = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    // Byte returned by the RAM this cycle belongs to the address issued one cycle earlier
    assign rd_idx = cnt_q[1:0] - 2'd1;
    assign wr_idx = cnt_q[1:0] + 2'd1;
    assign ram_wr = wr_q & rdy_in;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nb_d        = nb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        fetch_d     = fetch_q;
        wr_d        = 1'b0;
        ram_a_d     = ram_a;
        dout_d      = ram_dout;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data;
        mem_rdata_d = mem_rdata;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    state_d = mem_we ? WRITE : READ;
                    cnt_d   = 3'd0;
                    nb_d    = mem_nb;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    buf_d   = 32'd0;
                    fetch_d = 1'b0;
                    ram_a_d = mem_addr;
                    dout_d  = mem_wdata[7:0];
                    wr_d    = mem_we;
                end else if (if_req) begin
                    state_d = READ;
                    cnt_d   = 3'd0;
                    nb_d    = 3'd4;
                    addr_d  = if_addr;
                    buf_d   = 32'd0;
                    fetch_d = 1'b1;
                    ram_a_d = if_addr;
                end
            end
            READ: begin
                if (fetch_q && !if_req) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 3'd0)
                        buf_d[{rd_idx, 3'b000} +: 8] = ram_din;
                    cnt_d   = cnt_q + 3'd1;
                    ram_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
                    if (cnt_q == nb_q) begin
                        state_d = DONE;
                        if (fetch_q) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = buf_d;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt_q == nb_q - 3'd1) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    ram_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
                    dout_d  = wdata_q[{wr_idx, 3'b000} +: 8];
                    wr_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            nb_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            buf_q     <= 32'd0;
            fetch_q   <= 1'b0;
            wr_q      <= 1'b0;
            ram_a     <= 32'd0;
            ram_dout  <= 8'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nb_q      <= nb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
            fetch_q   <= fetch_d;
            wr_q      <= wr_d;
            ram_a     <= ram_a_d;
            ram_dout  <= dout_d;
            if_done   <= if_done_d;
            mem_done  <= mem_done_d;
            if_data   <= if_data_d;
            mem_rdata <= mem_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a byte RAM with one-cycle read latency plus a shadow byte-array reference model.
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_req, if_done, mem_req, mem_we, mem_done;
    logic        ram_wr, io_buffer_full, busy;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
    logic [1:0]  mem_len;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic [31:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          wr_k [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    always @(posedge clk_in) begin
        ram_din <= ram[ram_a[11:0]];
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    end

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ak;
        r = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            r  = r | (32'(shadow[ak[11:0]]) << (8 * k));
        end
        return r;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a[11:0]]    = b;
        shadow[a[11:0]] = b;
    endtask

    // Issues one access from IDLE and records writes and the done cycle relative to acceptance
    task automatic run_access(input bit fetch, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] len,
                              output int done_k, output logic [31:0] data);
        wr_a.delete(); wr_d.delete(); wr_k.delete();
        done_k = -1;
        data   = 32'd0;
        @(negedge clk_in);
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_len = len;
        end
        @(posedge clk_in);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (ram_wr) begin
                wr_a.push_back(ram_a); wr_d.push_back(ram_dout); wr_k.push_back(k);
            end
            if (if_done || mem_done) begin
                done_k = k;
                data   = fetch ? if_data : mem_rdata;
                break;
            end
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (if_done !== 1'b0)   begin errors++; $display("FAIL reset_if_done: got %b expected 0", if_done); end
        checks++; if (mem_done !== 1'b0)  begin errors++; $display("FAIL reset_mem_done: got %b expected 0", mem_done); end
        checks++; if (if_data !== 32'd0)  begin errors++; $display("FAIL reset_if_data: got %h expected 0", if_data); end
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
        checks++; if (ram_a !== 32'd0)    begin errors++; $display("FAIL reset_ram_a: got %h expected 0", ram_a); end
        checks++; if (ram_dout !== 8'd0)  begin errors++; $display("FAIL reset_ram_dout: got %h expected 0", ram_dout); end
        checks++; if (ram_wr !== 1'b0)    begin errors++; $display("FAIL reset_ram_wr: got %b expected 0", ram_wr); end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_fetch();
        int          dk;
        logic [31:0] d;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        run_access(1'b1, 1'b0, 32'h100, 32'd0, 2'd0, dk, d);
        checks++; if (dk !== 5) begin errors++; $display("FAIL fetch_done_cycle: got %0d expected 5", dk); end
        checks++; if (d !== 32'h00100513) begin errors++; $display("FAIL fetch_data: got %h expected 00100513", d); end
        checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL fetch_no_write: got %0d writes expected 0", wr_a.size()); end
        checks++; if (if_data !== 32'h00100513) begin errors++; $display("FAIL fetch_data_hold: got %h expected 00100513", if_data); end
    endtask

    task automatic test_priority();
        int          mk = -1;
        int          fk = -1;
        logic [31:0] md = 32'd0;
        logic [31:0] fd = 32'd0;
        poke(32'h200, 8'hFF);
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_len = 2'd0;
        @(posedge clk_in);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (mem_done && mk < 0) begin mk = k; md = mem_rdata; mem_req = 1'b0; end
            if (if_done && fk < 0) begin fk = k; fd = if_data; if_req = 1'b0; end
            if (fk >= 0) break;
        end
        if_req = 1'b0; mem_req = 1'b0;
        checks++; if (mk !== 2) begin errors++; $display("FAIL prio_mem_done_cycle: got %0d expected 2", mk); end
        checks++; if (md !== 32'h000000FF) begin errors++; $display("FAIL prio_mem_rdata: got %h expected 000000ff", md); end
        checks++; if (fk !== 9) begin errors++; $display("FAIL prio_if_done_cycle: got %0d expected 9", fk); end
        checks++; if (fd !== model_read(32'h100, 4)) begin errors++; $display("FAIL prio_if_data: got %h expected %h", fd, model_read(32'h100, 4)); end
        @(negedge clk_in);
    endtask

    task automatic test_store();
        int          dk;
        logic [31:0] d;
        run_access(1'b0, 1'b1, 32'h3FE, 32'hAABBCCDD, 2'd1, dk, d);
        shadow[12'h3FE] = 8'hDD; shadow[12'h3FF] = 8'hCC;
        checks++; if (dk !== 2) begin errors++; $display("FAIL store_done_cycle: got %0d expected 2", dk); end
        checks++;
        if (wr_a.size() != 2) begin
            errors++; $display("FAIL store_write_count: got %0d expected 2", wr_a.size());
        end else if (wr_a[0] !== 32'h3FE || wr_d[0] !== 8'hDD || wr_k[0] != 0 ||
                     wr_a[1] !== 32'h3FF || wr_d[1] !== 8'hCC || wr_k[1] != 1) begin
            errors++;
            $display("FAIL store_writes: got %h/%h@%0d %h/%h@%0d expected 3fe/dd@0 3ff/cc@1",
                     wr_a[0], wr_d[0], wr_k[0], wr_a[1], wr_d[1], wr_k[1]);
        end
        run_access(1'b0, 1'b0, 32'h3FE, 32'd0, 2'd1, dk, d);
        checks++; if (d !== 32'h0000CCDD) begin errors++; $display("FAIL store_readback: got %h expected 0000ccdd", d); end
    endtask

    task automatic test_wrap();
        int          dk;
        logic [31:0] d;
        logic [31:0] wd = 32'h01234567;
        logic [31:0] ea;
        run_access(1'b0, 1'b1, 32'hFFFFFFFE, wd, 2'd2, dk, d);
        checks++;
        if (wr_a.size() != 4) begin
            errors++; $display("FAIL wrap_write_count: got %0d expected 4", wr_a.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                ea = 32'hFFFFFFFE + 32'(k);
                checks++;
                if (wr_a[k] !== ea || wr_d[k] !== wd[8*k +: 8]) begin
                    errors++; $display("FAIL wrap_byte%0d: got %h/%h expected %h/%h", k, wr_a[k], wr_d[k], ea, wd[8*k +: 8]);
                end
                shadow[ea[11:0]] = wd[8*k +: 8];
            end
        end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h104;
        @(posedge clk_in);
        repeat (3) @(negedge clk_in);
        if_req = 1'b0;
        @(negedge clk_in);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
        for (int k = 0; k < 6; k++) begin @(negedge clk_in); if (if_done) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_done: got if_done pulse expected none"); end

        seen = 1'b0;
        @(negedge clk_in);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h55667788; mem_len = 2'd2;
        @(posedge clk_in);
        repeat (2) @(negedge clk_in);
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h501) begin errors++; $display("FAIL rst_pre_write: got wr=%b a=%h expected 1/501", ram_wr, ram_a); end
        rst_in = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk_in);
        checks++; if (ram_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_store: got wr=%b busy=%b expected 0/0", ram_wr, busy); end
        rst_in = 1'b0;
        shadow[12'h500] = 8'h88; shadow[12'h501] = 8'h77;
        for (int k = 0; k < 6; k++) begin @(negedge clk_in); if (mem_done || ram_wr) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL rst_no_done: got mem_done or ram_wr after reset expected none"); end
    endtask

    task automatic test_rdy();
        @(negedge clk_in);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h11223344; mem_len = 2'd1;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h600 || ram_dout !== 8'h44) begin errors++; $display("FAIL rdy_first_byte: got %b/%h/%h expected 1/600/44", ram_wr, ram_a, ram_dout); end
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checks++;
            if (ram_wr !== 1'b0 || busy !== 1'b1 || ram_a !== 32'h600) begin
                errors++; $display("FAIL rdy_freeze%0d: got wr=%b busy=%b a=%h expected 0/1/600", k, ram_wr, busy, ram_a);
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        checks++; if (ram_wr !== 1'b1 || ram_a !== 32'h601 || ram_dout !== 8'h33) begin errors++; $display("FAIL rdy_second_byte: got %b/%h/%h expected 1/601/33", ram_wr, ram_a, ram_dout); end
        @(negedge clk_in);
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL rdy_done: got %b expected 1", mem_done); end
        rdy_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL rdy_done_hold%0d: got done=%b wr=%b expected 1/0", k, mem_done, ram_wr); end
        end
        rdy_in = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk_in);
        checks++; if (mem_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rdy_release: got done=%b busy=%b expected 0/0", mem_done, busy); end
        shadow[12'h600] = 8'h44; shadow[12'h601] = 8'h33;
    endtask

    task automatic test_io_full();
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h30000; mem_wdata = 32'hCAFEBABE; mem_len = 2'd0;
`ifdef MEM_CTRL_IO_FULL_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checks++; if (busy !== 1'b0 || ram_wr !== 1'b0) begin errors++; $display("FAIL iofull_hold%0d: got busy=%b wr=%b expected 0/0", k, busy, ram_wr); end
        end
        io_buffer_full = 1'b0;
`endif
        @(negedge clk_in);
        checks++; if (busy !== 1'b1 || ram_wr !== 1'b1 || ram_a !== 32'h30000 || ram_dout !== 8'hBE) begin
            errors++; $display("FAIL iofull_accept: got busy=%b wr=%b a=%h d=%h expected 1/1/30000/be", busy, ram_wr, ram_a, ram_dout);
        end
        @(negedge clk_in);
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL iofull_done: got %b expected 1", mem_done); end
        mem_req = 1'b0; mem_we = 1'b0; io_buffer_full = 1'b0;
        @(negedge clk_in);
        shadow[12'h000] = 8'hBE;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int          op;
            int          n;
            int          dk;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] d;
            logic [31:0] ex;
            logic [31:0] ea;
            logic [1:0]  len;
            op  = $urandom_range(0, 2);
            wd  = $urandom;
            len = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 4095));
            n   = (op == 0) ? 4 : nbytes(len);
            ex  = model_read(a, n);
            run_access(op == 0, op == 2, a, wd, len, dk, d);
            checks++;
            if (dk !== ((op == 2) ? n : n + 1)) begin
                errors++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, dk, (op == 2) ? n : n + 1);
            end
            checks++;
            if (op != 2) begin
                if (d !== ex || wr_a.size() != 0) begin
                    errors++; $display("FAIL rand%0d_read: got %h (%0d writes) expected %h", it, d, wr_a.size(), ex);
                end
            end else if (wr_a.size() != n) begin
                errors++; $display("FAIL rand%0d_write_count: got %0d expected %0d", it, wr_a.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    ea = a + 32'(k);
                    checks++;
                    if (wr_a[k] !== ea || wr_d[k] !== wd[8*k +: 8] || wr_k[k] != k) begin
                        errors++; $display("FAIL rand%0d_byte%0d: got %h/%h@%0d expected %h/%h@%0d",
                                           it, k, wr_a[k], wr_d[k], wr_k[k], ea, wd[8*k +: 8], k);
                    end
                    shadow[ea[11:0]] = wd[8*k +: 8];
                end
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_len = 2'd0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            ram[i] = b; shadow[i] = b;
        end
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_wrap();
        test_abort();
        test_rdy();
        test_io_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_in  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: rdy_in  in  1  global enable; low freezes all state.
REQ-004 SHALL have ports: if_req  in  1  fetch request, level, held until if_done; if_addr  in  32  fetch byte address.
REQ-005 SHALL have ports: if_done  out  1  one-cycle completion pulse; if_data  out  32  fetched word.
REQ-006 SHALL have ports: mem_req  in  1  load/store request, level; mem_we  in  1  1=store; mem_addr  in  32; mem_wdata  in  32; mem_len  in  2  (0=1B, 1=2B, 2=4B, 3 treated as 4B).
REQ-007 SHALL have ports: mem_done  out  1  one-cycle pulse; mem_rdata  out  32  load data, zero-extended.
REQ-008 SHALL have ports: ram_din  in  8  RAM read byte; ram_dout  out  8; ram_a  out  32; ram_wr  out  1  (1=write); io_buffer_full  in  1.
REQ-009 SHALL have ports: busy  out  1  high whenever state is not IDLE.

Function
REQ-010 SHALL share one byte-wide RAM port between fetch and load/store, serialising bytes little-endian (byte k at addr+k into bits 8k+7:8k).
REQ-011 SHALL implement states IDLE, READ, WRITE, DONE; a request is accepted only in IDLE.
REQ-012 SHALL give mem_req priority over if_req when both are high in IDLE; no preemption of an accepted access.
REQ-013 SHALL latch address, length, write data and requester on the acceptance edge E0; later input changes (except REQ-018) are ignored.
REQ-014 SHALL, for a read of N bytes, drive ram_a=addr+k, ram_wr=0 in cycle k after E0 (k=0..N-1), capture ram_din at edge E(k+2) (one-cycle RAM latency), and raise done for cycle N+1 after E0; word fetch = 5 cycles.
REQ-015 SHALL, for a write of N bytes, drive ram_a=addr+k, ram_dout=byte k, ram_wr=1 in cycle k, and raise mem_done in cycle N after E0.
REQ-016 SHALL hold exactly one DONE cycle after every completion, accepting no request there; if_data/mem_rdata stable from done until the next acceptance.
REQ-017 SHALL drive ram_wr=0 in every cycle not listed in REQ-015, including DONE, IDLE and rdy_in-low cycles.
REQ-018 SHALL abort an accepted fetch if if_req is low at any edge before completion: return to IDLE, no if_done; writes and loads are never aborted.
REQ-019 SHALL, while rdy_in=0, hold state, counter and outputs, with done pulses extended until rdy_in returns.
REQ-020 SHALL compute ram_a with 32-bit wrap-around (0xFFFFFFFF+1 = 0x00000000).

Reset
REQ-021 SHALL on rst_in=1 enter IDLE, clear byte counter, and drive if_done=0, mem_done=0, if_data=0, mem_rdata=0, ram_a=0, ram_dout=0, ram_wr=0, busy=0.
REQ-022 SHALL, on reset mid-access, abandon it with no done pulse and ram_wr=0 from the next cycle.
REQ-023 SHALL give rst_in priority over rdy_in.

Configuration
REQ-024 SHALL, with MEM_CTRL_IO_FULL_EN defined, not accept a store with mem_addr[17:16]=2'b11 while io_buffer_full=1; store stays pending, a pending if_req may be accepted meanwhile.
REQ-025 SHALL, without MEM_CTRL_IO_FULL_EN, ignore io_buffer_full entirely.

Verification
REQ-026 SHALL cover: if_req, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> if_done in cycle 5 after E0, if_data=0x00100513.
REQ-027 SHALL cover: if_req and mem_req (load, len=0, addr 0x200 holding 0xFF) both high in IDLE -> mem_done first, mem_rdata=0x000000FF, fetch accepted after DONE.
REQ-028 SHALL cover: store len=1, addr 0x3FE, wdata 0xAABBCCDD -> ram_wr=1 with 0x3FE/0xDD then 0x3FF/0xCC, mem_done cycle 2.
REQ-029 SHALL cover: if_req dropped in cycle 2 of fetch -> no if_done, IDLE next cycle; rst_in during store byte 1 -> ram_wr=0 next cycle, no mem_done.
REQ-030 SHALL cover: MEM_CTRL_IO_FULL_EN, store to 0x30000 with io_buffer_full=1 for 3 cycles -> no ram_wr; accepted on first edge with io_buffer_full=0.
